// File: rtl/seq_divider.sv
// Multi-cycle signed 32-bit divider: restoring division on magnitudes, one quotient bit per cycle,
// with signs applied when the result is published. Divide-by-zero short-circuits straight to DONE.
module seq_divider #(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] data_operandA,
    input  logic [DATA_W-1:0] data_operandB,
    input  logic              ctrl_DIV,
    output logic [DATA_W-1:0] data_result,
    output logic [DATA_W-1:0] data_remainder,
    output logic              data_exception,
    output logic              data_resultRDY,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [5:0] LAST_STEP = 6'(DATA_W - 1);

    state_t                   state, state_nxt;
    logic                     accept;
    logic [5:0]               count;

    logic signed [DATA_W-1:0] op_a, op_b;
    logic [DATA_W-1:0]        dvd, dvs, quo, rem;
    logic                     sign_a, sign_b, div_zero;

    logic [DATA_W:0]          diff;
    logic                     q_bit;
    logic [DATA_W-1:0]        rem_step;

    function automatic logic [DATA_W-1:0] abs_val(input logic signed [DATA_W-1:0] v);
        // The most negative value wraps to itself, which is exactly its magnitude as unsigned.
        return v[DATA_W-1] ? DATA_W'(-v) : DATA_W'(v);
    endfunction

    function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] mag,
                                                     input logic              neg);
        return neg ? DATA_W'(-mag) : mag;
    endfunction

    assign op_a = data_operandA;
    assign op_b = data_operandB;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (ctrl_DIV) begin
                    accept    = 1'b1;
                    state_nxt = (op_b == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (count == LAST_STEP) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The partial remainder is always below |B| <= 2^31, so a 33-bit difference keeps a valid sign bit.
    always_comb begin
        diff     = {rem, dvd[DATA_W-1]} - {1'b0, dvs};
        q_bit    = ~diff[DATA_W];
        rem_step = q_bit ? diff[DATA_W-1:0] : {rem[DATA_W-2:0], dvd[DATA_W-1]};
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            dvd      <= abs_val(op_a);
            dvs      <= abs_val(op_b);
            quo      <= '0;
            rem      <= '0;
            sign_a   <= op_a[DATA_W-1];
            sign_b   <= op_b[DATA_W-1];
            div_zero <= (op_b == '0);
        end else if (state == RUN) begin
            dvd <= {dvd[DATA_W-2:0], 1'b0};
            quo <= {quo[DATA_W-2:0], q_bit};
            rem <= rem_step;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            count          <= '0;
            data_result    <= '0;
            data_remainder <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state          <= state_nxt;
            data_resultRDY <= (state == DONE);
            // Stays high through the ready-pulse cycle; a held start re-raises it on the next edge.
            busy           <= accept || (state != IDLE);
            if (accept) begin
                count <= '0;
            end else if (state == RUN) begin
                count <= count + 6'd1;
            end
            if (state == DONE) begin
                data_result    <= apply_sign(quo, sign_a ^ sign_b);
                data_remainder <= apply_sign(rem, sign_a);
                data_exception <= div_zero;
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: each accepted start pushes its expected outcome and ready
// edge count; a negedge monitor pops and compares whenever data_resultRDY is seen.
module tb_seq_divider;

    logic        clock;
    logic        reset_n;
    logic [31:0] data_operandA, data_operandB;
    logic        ctrl_DIV;
    logic [31:0] data_result, data_remainder;
    logic        data_exception, data_resultRDY, busy;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        e;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_cnt = 0;
    logic rdy_prev = 1'b0;

    seq_divider dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .data_operandA (data_operandA),
        .data_operandB (data_operandB),
        .ctrl_DIV      (ctrl_DIV),
        .data_result   (data_result),
        .data_remainder(data_remainder),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY),
        .busy          (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: 64-bit signed division truncates toward zero and avoids the -2^31 / -1 overflow.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int now);
        exp_t   x;
        longint sa, sbv, lq, lr;
        if (b == 32'd0) begin
            x.q = 32'd0; x.r = 32'd0; x.e = 1'b1; x.cyc = now + 2;
        end else begin
            sa  = longint'($signed(a));
            sbv = longint'($signed(b));
            lq  = sa / sbv;
            lr  = sa % sbv;
            x.q = lq[31:0]; x.r = lr[31:0]; x.e = 1'b0; x.cyc = now + 34;
        end
        return x;
    endfunction

    always @(negedge clock) begin
        if (reset_n && data_resultRDY) begin
            chk("rdy_pulse_width", {31'd0, rdy_prev}, 32'd0);
            chk("busy_at_rdy", {31'd0, busy}, 32'd1);
            if (sb.size() == 0) begin
                chk("unexpected_rdy", 32'd1, 32'd0);
            end else begin
                exp_t x;
                x = sb.pop_front();
                chk("rdy_latency", edge_cnt, x.cyc);
                chk("quotient", data_result, x.q);
                chk("remainder", data_remainder, x.r);
                chk("exception", {31'd0, data_exception}, {31'd0, x.e});
            end
        end
        rdy_prev = data_resultRDY;
    end

    task automatic start_div(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_DIV      = 1'b1;
        sb.push_back(model(a, b, edge_cnt));
        @(negedge clock);
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 120 && sb.size() > 0; i++) @(negedge clock);
        if (sb.size() > 0) begin
            chk("timeout_pending", sb.size(), 32'd0);
            sb.delete();
        end
        @(negedge clock);
        @(negedge clock);
        chk("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [31:0] a, b;
        reset_n       = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_result", data_result, 32'd0);
        chk("rst_rdy", {31'd0, data_resultRDY}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        start_div(32'd100, 32'd7);              wait_idle();
        start_div(32'hFFFFFF9C, 32'd7);         wait_idle();
        start_div(32'd5, 32'd0);                wait_idle();
        start_div(32'h80000000, 32'hFFFFFFFF);  wait_idle();
        start_div(32'h80000000, 32'd1);         wait_idle();
        start_div(32'd7, 32'hFFFFFFFE);         wait_idle();
        start_div(32'd0, 32'hFFFFFFF9);         wait_idle();

        // A start request while busy must be dropped entirely.
        start_div(32'd50, 32'd5);
        repeat (8) @(negedge clock);
        data_operandA = 32'd9;
        data_operandB = 32'd3;
        ctrl_DIV      = 1'b1;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        chk("busy_ignored_start", {31'd0, busy}, 32'd1);
        wait_idle();

        // Reset in the middle of an operation: outputs clear at once and no ready pulse follows.
        start_div(32'd1000, 32'd10);
        repeat (13) @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_result", data_result, 32'd0);
        chk("midrst_remainder", data_remainder, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        sb.delete();
        @(negedge clock);
        reset_n = 1'b1;
        repeat (40) @(negedge clock);
        start_div(32'd1000, 32'd10);            wait_idle();

        // Start held high: the second operation begins on the edge right after the ready cycle.
        @(negedge clock);
        data_operandA = 32'd77;
        data_operandB = 32'd5;
        ctrl_DIV      = 1'b1;
        sb.push_back(model(32'd77, 32'd5, edge_cnt));
        begin
            int n = 0;
            while (!data_resultRDY && n < 60) begin
                @(negedge clock);
                n++;
            end
            if (!data_resultRDY) chk("b2b_timeout", 32'd1, 32'd0);
        end
        data_operandA = 32'hFFFFFC18;
        data_operandB = 32'd3;
        sb.push_back(model(32'hFFFFFC18, 32'd3, edge_cnt));
        @(negedge clock);
        ctrl_DIV = 1'b0;
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        wait_idle();

        for (int i = 0; i < 10; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            if (i == 4) b = 32'hFFFFFFFF;
            if (i == 7) a = 32'h80000000;
            start_div(a, b);
            wait_idle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
